// File: rtl/car_link_pkg.sv
// Definitions shared by both ends of the car control link: the transmitter's
// state type, the width of the control byte and where each field sits in it.
package car_link_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } link_state_t;

   localparam int DATA_BITS = 8;

   localparam int MODE_LSB     = 0;
   localparam int SPEED_LSB    = 2;
   localparam int BACKWARD_BIT = 4;
   localparam int RUN_BIT      = 5;
   localparam int LEFT_BIT     = 6;
   localparam int RIGHT_BIT    = 7;

   localparam logic [1:0] MODE_AUTO = 2'b10;

   // True when the mode field of a control byte selects autonomous driving.
   function automatic logic is_auto_mode(input logic [DATA_BITS-1:0] ctl);
      return (ctl[MODE_LSB +: 2] == MODE_AUTO);
   endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Free-running bit-period timer. Counts 0..CLKS_PER_BIT-1 and wraps; clear
// restarts the count so bit boundaries line up with the start of a frame.
module uart_baud_counter #(
   parameter int CLKS_PER_BIT = 10417
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   output logic bit_done
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] cnt_r;

   // Bit-period counter: restart on clear, wrap after the last cycle of a bit.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_r <= '0;
      end else if (clear) begin
         cnt_r <= '0;
      end else if (cnt_r == LAST) begin
         cnt_r <= '0;
      end else begin
         cnt_r <= cnt_r + CW'(1);
      end
   end

   assign bit_done = (cnt_r == LAST);

endmodule

// File: rtl/car_control_tx.sv
// Controller-side transmitter for the car control link. Sends the control
// byte as an 8N1 UART frame whenever it changes, when asked to, or when the
// keepalive interval runs out. serial, busy and sent are all registered.
module car_control_tx
   import car_link_pkg::*;
#(
   parameter int CLKS_PER_BIT     = 10417,
   parameter int KEEPALIVE_CYCLES = 10000000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] control_in,
   input  logic       send_req,
   output logic       serial,
   output logic       busy,
   output logic       sent
);

   localparam bit KA_EN = (KEEPALIVE_CYCLES != 0);
   localparam int KA_W  = (KEEPALIVE_CYCLES > 1) ? $clog2(KEEPALIVE_CYCLES) : 1;
   localparam logic [KA_W-1:0] KA_MAX = KA_W'(KEEPALIVE_CYCLES - 1);

   link_state_t          state_r, state_s;
   logic [DATA_BITS-1:0] shift_r, shift_s;
   logic [DATA_BITS-1:0] last_sent_r, last_sent_s;
   logic                 pending_r, pending_s;
   logic [2:0]           bit_cnt_r, bit_cnt_s;
   logic [KA_W-1:0]      ka_cnt_r;
   logic                 serial_r, serial_s;
   logic                 busy_r, busy_s;
   logic                 sent_r, sent_s;
   logic                 start_s;
   logic                 trigger_s;
   logic                 expired_s;
   logic                 bit_done_s;

   uart_baud_counter #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud (
      .clk      (clk),
      .reset    (reset),
      .clear    (start_s),
      .bit_done (bit_done_s)
   );

   assign expired_s = KA_EN && (ka_cnt_r == KA_MAX);
   assign trigger_s = pending_r | send_req | (control_in != last_sent_r) | expired_s;

   // Keepalive timer: saturating count of cycles since the last frame start.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ka_cnt_r <= '0;
      end else if (!KA_EN) begin
         ka_cnt_r <= '0;
      end else if (start_s) begin
         ka_cnt_r <= '0;
      end else if (ka_cnt_r != KA_MAX) begin
         ka_cnt_r <= ka_cnt_r + KA_W'(1);
      end else begin
         ka_cnt_r <= ka_cnt_r;
      end
   end

   // Frame sequencer state and registered line outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r     <= IDLE;
         shift_r     <= 8'h00;
         last_sent_r <= 8'h00;
         pending_r   <= 1'b0;
         bit_cnt_r   <= 3'd0;
         serial_r    <= 1'b1;
         busy_r      <= 1'b0;
         sent_r      <= 1'b0;
      end else begin
         state_r     <= state_s;
         shift_r     <= shift_s;
         last_sent_r <= last_sent_s;
         pending_r   <= pending_s;
         bit_cnt_r   <= bit_cnt_s;
         serial_r    <= serial_s;
         busy_r      <= busy_s;
         sent_r      <= sent_s;
      end
   end

   // Next state plus the output values the line will show next cycle.
   always_comb begin
      state_s     = state_r;
      shift_s     = shift_r;
      last_sent_s = last_sent_r;
      bit_cnt_s   = bit_cnt_r;
      pending_s   = pending_r | (send_req & (state_r != IDLE));
      start_s     = 1'b0;
      serial_s    = 1'b1;
      busy_s      = 1'b0;
      sent_s      = 1'b0;

      case (state_r)
         IDLE: begin
            if (trigger_s) begin
               state_s     = START;
               shift_s     = control_in;
               last_sent_s = control_in;
               pending_s   = 1'b0;
               bit_cnt_s   = 3'd0;
               start_s     = 1'b1;
               serial_s    = 1'b0;
               busy_s      = 1'b1;
            end else begin
               serial_s = 1'b1;
               busy_s   = 1'b0;
            end
         end
         START: begin
            busy_s = 1'b1;
            if (bit_done_s) begin
               state_s  = DATA;
               serial_s = shift_r[0];
            end else begin
               serial_s = 1'b0;
            end
         end
         DATA: begin
            busy_s = 1'b1;
            if (bit_done_s) begin
               if (bit_cnt_r == 3'(DATA_BITS - 1)) begin
                  state_s   = STOP;
                  bit_cnt_s = 3'd0;
                  serial_s  = 1'b1;
               end else begin
                  shift_s   = {1'b0, shift_r[DATA_BITS-1:1]};
                  bit_cnt_s = bit_cnt_r + 3'd1;
                  serial_s  = shift_r[1];
               end
            end else begin
               serial_s = shift_r[0];
            end
         end
         STOP: begin
            serial_s = 1'b1;
            if (bit_done_s) begin
               state_s = IDLE;
               busy_s  = 1'b0;
               sent_s  = 1'b1;
            end else begin
               busy_s = 1'b1;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   assign serial = serial_r;
   assign busy   = busy_r;
   assign sent   = sent_r;

endmodule
